// File: rtl/move_input_ctrl.sv
// move_input_ctrl: turns raw column switches and player buttons into clean, validated one-shot moves
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   col_sw           : raw column-select switches (one per column)
//   btn_p1, btn_p2   : raw player drop buttons, active-high
//   clear            : single-cycle new-game request (keeps input conditioning state)
//   move_valid/col/player, move_ready : move request handshake towards the board stage
//   turn             : player expected next (0 = P1, 1 = P2)
//   col_full         : per-column full flags
//   illegal_move     : one-cycle pulse when a press is rejected
module move_input_ctrl #(
    parameter int NUM_COLS        = 8,
    parameter int NUM_ROWS        = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] col_sw,
    input  logic                btn_p1,
    input  logic                btn_p2,
    input  logic                clear,
    output logic                move_valid,
    output logic [2:0]          move_col,
    output logic                move_player,
    input  logic                move_ready,
    output logic                turn,
    output logic [NUM_COLS-1:0] col_full,
    output logic                illegal_move
);
    localparam int W = NUM_COLS + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RELEASE} state_t;

    logic [W-1:0]        sync1_q, sync2_q, lvl_q, lvl_d;
    logic [CNT_W-1:0]    cnt_q [W];
    logic [CNT_W-1:0]    cnt_d [W];
    logic [1:0]          btn_prev_q, rise;
    logic [NUM_COLS-1:0] col_db, full_q, full_d;
    logic                b1, b2, onehot, btn_ok, legal;
    logic [2:0]          idx;
    state_t              state_q, state_d;
    logic                valid_q, valid_d, player_q, player_d, turn_q, turn_d, illegal_q, illegal_d;
    logic [2:0]          col_q, col_d;
    logic [2:0]          height_q [NUM_COLS];
    logic [2:0]          height_d [NUM_COLS];

    // Debounce: the level only flips after the synchronised input has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        for (int i = 0; i < W; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = ~lvl_q[i];
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            btn_prev_q <= '0;
            for (int i = 0; i < W; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= {btn_p2, btn_p1, col_sw};
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            btn_prev_q <= lvl_q[W-1:W-2];
            for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign col_db = lvl_q[NUM_COLS-1:0];
    assign b1     = lvl_q[NUM_COLS];
    assign b2     = lvl_q[NUM_COLS+1];
    assign rise   = {b2, b1} & ~btn_prev_q;
    assign onehot = (col_db != '0) && ((col_db & (col_db - NUM_COLS'(1))) == '0);
    assign btn_ok = turn_q ? (rise == 2'b10) : (rise == 2'b01);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_COLS; i++) if (col_db[i]) idx = 3'(i);
    end

    assign legal = btn_ok && onehot && !full_q[idx];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        col_d     = col_q;
        player_d  = player_q;
        turn_d    = turn_q;
        illegal_d = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) height_d[i] = height_q[i];
        case (state_q)
            IDLE: if (rise != 2'b00) begin
                if (legal) begin
                    col_d    = idx;
                    player_d = turn_q;
                    valid_d  = 1'b1;
                    state_d  = ISSUE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = WAIT_RELEASE;
                end
            end
            ISSUE: if (move_ready) begin
                height_d[col_q] = height_q[col_q] + ((height_q[col_q] != 3'd7) ? 3'd1 : 3'd0);
                turn_d          = ~turn_q;
                valid_d         = 1'b0;
                state_d         = WAIT_RELEASE;
            end
            WAIT_RELEASE: state_d = (!b1 && !b2) ? IDLE : WAIT_RELEASE;
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < NUM_COLS; i++) full_d[i] = (height_d[i] == 3'(NUM_ROWS));
    end

    // clear wins over a same-cycle handshake: the pending move is simply discarded
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            col_q     <= '0;
            player_q  <= 1'b0;
            turn_q    <= 1'b0;
            illegal_q <= 1'b0;
            full_q    <= '0;
            for (int i = 0; i < NUM_COLS; i++) height_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            col_q     <= col_d;
            player_q  <= player_d;
            turn_q    <= turn_d;
            illegal_q <= illegal_d;
            full_q    <= full_d;
            for (int i = 0; i < NUM_COLS; i++) height_q[i] <= height_d[i];
        end
    end

    assign move_valid   = valid_q;
    assign move_col     = col_q;
    assign move_player  = player_q;
    assign turn         = turn_q;
    assign col_full     = full_q;
    assign illegal_move = illegal_q;
endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: self-checking bench for move_input_ctrl with a short debounce
module tb_move_input_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] col_sw = '0;
    logic       btn_p1 = 1'b0, btn_p2 = 1'b0, clear = 1'b0, move_ready = 1'b1;
    logic       move_valid, move_player, turn, illegal_move;
    logic [2:0] move_col;
    logic [7:0] col_full;

    int total = 0;
    int bad = 0;

    move_input_ctrl #(.NUM_COLS(8), .NUM_ROWS(6), .DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clock(clock), .reset(reset), .col_sw(col_sw), .btn_p1(btn_p1), .btn_p2(btn_p2),
        .clear(clear), .move_valid(move_valid), .move_col(move_col), .move_player(move_player),
        .move_ready(move_ready), .turn(turn), .col_full(col_full), .illegal_move(illegal_move)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] c;
        logic       p1;
        logic       p2;
        int         nv;
        int         ni;
        logic [2:0] col;
        logic       pl;
        logic       turn_after;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        btn_p1 = 1'b0;
        btn_p2 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Settle the switches, hold the button(s) long enough to debounce, then release and settle again
    task automatic do_press(input logic [7:0] c, input logic p1, input logic p2,
                            output int nv, output int ni, output logic [2:0] fc, output logic fp);
        nv = 0;
        ni = 0;
        fc = '0;
        fp = 1'b0;
        col_sw = c;
        repeat (10) @(negedge clock);
        btn_p1 = p1;
        btn_p2 = p2;
        repeat (25) begin
            @(negedge clock);
            if (move_valid) begin
                if (nv == 0) begin
                    fc = move_col;
                    fp = move_player;
                end
                nv++;
            end
            if (illegal_move) ni++;
        end
        btn_p1 = 1'b0;
        btn_p2 = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    int         nv, ni, cnt;
    logic [2:0] fc;
    logic       fp, seen, stable;
    int         h [8];
    logic       t;

    initial begin
        tbl[0] = '{8'h04, 1'b1, 1'b0, 1, 0, 3'd2, 1'b0, 1'b1};
        tbl[1] = '{8'h01, 1'b1, 1'b0, 0, 1, 3'd0, 1'b0, 1'b1};
        tbl[2] = '{8'h01, 1'b0, 1'b1, 1, 0, 3'd0, 1'b1, 1'b0};
        tbl[3] = '{8'h01, 1'b0, 1'b1, 0, 1, 3'd0, 1'b0, 1'b0};
        tbl[4] = '{8'h18, 1'b1, 1'b0, 0, 1, 3'd0, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 1'b0, 0, 1, 3'd0, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 0, 1, 3'd0, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 1'b1, 1'b0, 1, 0, 3'd7, 1'b0, 1'b1};

        do_reset();
        @(negedge clock);
        chk("rst_valid", 32'(move_valid), 0);
        chk("rst_col", 32'(move_col), 0);
        chk("rst_player", 32'(move_player), 0);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_full", 32'(col_full), 0);
        chk("rst_illegal", 32'(illegal_move), 0);

        for (int i = 0; i < 8; i++) begin
            do_press(tbl[i].c, tbl[i].p1, tbl[i].p2, nv, ni, fc, fp);
            chk($sformatf("tbl%0d_nvalid", i), 32'(nv), 32'(tbl[i].nv));
            chk($sformatf("tbl%0d_nillegal", i), 32'(ni), 32'(tbl[i].ni));
            if (tbl[i].nv == 1) begin
                chk($sformatf("tbl%0d_col", i), 32'(fc), 32'(tbl[i].col));
                chk($sformatf("tbl%0d_player", i), 32'(fp), 32'(tbl[i].pl));
            end
            chk($sformatf("tbl%0d_turn", i), 32'(turn), 32'(tbl[i].turn_after));
        end

        // Fill column 5, then try a seventh drop
        do_reset();
        for (int k = 0; k < 6; k++) begin
            do_press(8'h20, k % 2 == 0, k % 2 == 1, nv, ni, fc, fp);
            chk($sformatf("fill%0d_nvalid", k), 32'(nv), 1);
            chk($sformatf("fill%0d_full", k), 32'(col_full), (k == 5) ? 32'h20 : 32'h0);
        end
        do_press(8'h20, 1'b1, 1'b0, nv, ni, fc, fp);
        chk("full_nvalid", 32'(nv), 0);
        chk("full_nillegal", 32'(ni), 1);
        chk("full_turn", 32'(turn), 0);

        // Back-pressure: move held stable while switches change
        do_reset();
        move_ready = 1'b0;
        col_sw = 8'h04;
        repeat (10) @(negedge clock);
        btn_p1 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clock);
            seen = move_valid;
        end
        chk("stall_valid_seen", 32'(seen), 1);
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) col_sw = 8'h10;
            if (k == 12) col_sw = 8'h41;
            @(negedge clock);
            if (!(move_valid && move_col == 3'd2 && move_player == 1'b0)) stable = 1'b0;
        end
        chk("stall_stable", 32'(stable), 1);
        move_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (move_valid) cnt++;
        end
        chk("stall_after_valid", 32'(cnt), 0);
        chk("stall_turn", 32'(turn), 1);
        btn_p1 = 1'b0;
        repeat (10) @(negedge clock);

        // Bouncing button gives exactly one move
        do_reset();
        move_ready = 1'b1;
        col_sw = 8'h08;
        repeat (10) @(negedge clock);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            btn_p1 = ~btn_p1;
            repeat (2) begin
                @(negedge clock);
                if (move_valid) cnt++;
            end
        end
        btn_p1 = 1'b1;
        repeat (25) begin
            @(negedge clock);
            if (move_valid) begin
                cnt++;
                chk("bounce_col", 32'(move_col), 3);
            end
        end
        chk("bounce_nvalid", 32'(cnt), 1);
        chk("bounce_turn", 32'(turn), 1);
        btn_p1 = 1'b0;
        repeat (10) @(negedge clock);

        // clear in the handshake cycle drops the move
        move_ready = 1'b0;
        btn_p2 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clock);
            seen = move_valid;
        end
        chk("clr_valid_seen", 32'(seen), 1);
        move_ready = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_valid", 32'(move_valid), 0);
        chk("clr_turn", 32'(turn), 0);
        chk("clr_full", 32'(col_full), 0);
        chk("clr_col", 32'(move_col), 0);
        btn_p2 = 1'b0;
        repeat (10) @(negedge clock);
        do_press(8'h08, 1'b1, 1'b0, nv, ni, fc, fp);
        chk("clr_next_nvalid", 32'(nv), 1);
        chk("clr_next_player", 32'(fp), 0);

        // Randomised transactions against a column-height/turn model
        do_reset();
        move_ready = 1'b1;
        t = 1'b0;
        for (int i = 0; i < 8; i++) h[i] = 0;
        for (int n = 0; n < 40; n++) begin
            int         kind, bsel, a, b, sel;
            logic [7:0] c;
            logic       p1, p2, lg;
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 2);
            b = (a + 1 + $urandom_range(0, 6)) % 8;
            c = (kind < 7) ? (8'd1 << a) : (kind == 7) ? 8'h00 : ((8'd1 << a) | (8'd1 << b));
            bsel = $urandom_range(0, 4);
            p1 = (bsel < 3) ? !t : (bsel == 3) ? t : 1'b1;
            p2 = (bsel < 3) ? t : (bsel == 3) ? !t : 1'b1;
            sel = 0;
            for (int i = 0; i < 8; i++) if (c[i]) sel = i;
            lg = (p1 != p2) && (p2 == t) && ($countones(c) == 1) && (h[sel] < 6);
            do_press(c, p1, p2, nv, ni, fc, fp);
            chk($sformatf("rnd%0d_nvalid", n), 32'(nv), lg ? 1 : 0);
            chk($sformatf("rnd%0d_nillegal", n), 32'(ni), lg ? 0 : 1);
            if (lg) begin
                chk($sformatf("rnd%0d_col", n), 32'(fc), 32'(sel));
                chk($sformatf("rnd%0d_player", n), 32'(fp), 32'(t));
                h[sel]++;
                t = !t;
            end
            chk($sformatf("rnd%0d_turn", n), 32'(turn), 32'(t));
            for (int i = 0; i < 8; i++) chk($sformatf("rnd%0d_full%0d", n, i), 32'(col_full[i]), (h[i] == 6) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
